// File: rtl/mem_pkg.sv
// Shared types and defaults for the burst memory controller.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    WAIT   = 2'd3
  } state_t;

  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

  localparam int DEF_DWIDTH      = 32;
  localparam int DEF_AWIDTH      = 8;
  localparam int DEF_CPU_AWIDTH  = 16;
  localparam int DEF_WAIT_CYCLES = 2;
  localparam int DEF_BWIDTH      = 2;

  // Wide enough for the full 0..15 range of WAIT_CYCLES.
  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/mem_wait_timer.sv
// Loadable down-counter with a zero flag; times the per-beat WAIT interval.
module mem_wait_timer
  import mem_pkg::*;
#(
  parameter int CNT_W = WAIT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_burst_ctrl.sv
// CPU-to-RAM burst controller: one request becomes Burst_len+1 fixed-latency
// beats at incrementing (wrapping) RAM addresses, each SETUP -> ACCESS -> WAIT.
module mem_burst_ctrl
  import mem_pkg::*;
#(
  parameter int DWIDTH      = DEF_DWIDTH,
  parameter int AWIDTH      = DEF_AWIDTH,
  parameter int CPU_AWIDTH  = DEF_CPU_AWIDTH,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int BWIDTH      = DEF_BWIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Valid,
  input  logic                  RW,
  input  logic [CPU_AWIDTH-1:0] Addr_in,
  input  logic [BWIDTH-1:0]     Burst_len,
  input  logic [DWIDTH-1:0]     Wdata,
  output logic [DWIDTH-1:0]     Rdata,
  output logic                  Ready,
  output logic                  Beat_done,
  output logic                  Last,
  output logic                  rdEn,
  output logic                  wrEn,
  output logic [AWIDTH-1:0]     Addr,
  output logic [DWIDTH-1:0]     Mem_wdata,
  input  logic [DWIDTH-1:0]     Mem_rdata,
  output state_t                o_dbg_state
);

  localparam logic [WAIT_CNT_W-1:0] LP_WAIT = WAIT_CNT_W'(WAIT_CYCLES);

  state_t              r_state;
  state_t              w_next;
  logic [AWIDTH-1:0]   r_addr;
  logic                r_rw;
  logic [BWIDTH-1:0]   r_len;
  logic [BWIDTH-1:0]   r_beat;
  logic                w_accept;
  logic                w_setup;
  logic                w_load;
  logic                w_dec;
  logic                w_zero;
  logic                w_complete;
  logic                w_last_beat;
  logic                w_unused_addr;

  assign w_unused_addr = ^Addr_in[CPU_AWIDTH-1:AWIDTH];
  assign w_last_beat   = (r_beat == r_len);
  assign o_dbg_state   = r_state;

  mem_wait_timer #(.CNT_W(WAIT_CNT_W)) u_wait_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (LP_WAIT),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Request handshake: a request transfers on an edge where Valid and Ready are
  // both high. Ready is high exactly in IDLE, so Valid elsewhere is dropped.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (Valid) w_next = SETUP;
      SETUP:   w_next = ACCESS;
      ACCESS:  w_next = WAIT;
      WAIT:    if (w_zero) w_next = w_last_beat ? IDLE : SETUP;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_accept   = 1'b0;
    w_setup    = 1'b0;
    w_load     = 1'b0;
    w_dec      = 1'b0;
    w_complete = 1'b0;
    case (r_state)
      IDLE:   w_accept = Valid;
      SETUP:  w_setup  = 1'b1;
      ACCESS: w_load   = 1'b1;
      WAIT: begin
        w_dec      = ~w_zero;
        w_complete = w_zero;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Rdata     <= '0;
      Ready     <= 1'b1;
      Beat_done <= 1'b0;
      Last      <= 1'b0;
      rdEn      <= 1'b0;
      wrEn      <= 1'b0;
      Addr      <= '0;
      Mem_wdata <= '0;
      r_addr    <= '0;
      r_rw      <= 1'b0;
      r_len     <= '0;
      r_beat    <= '0;
    end else begin
      Beat_done <= 1'b0;
      Last      <= 1'b0;
      if (w_accept) begin
        r_addr <= Addr_in[AWIDTH-1:0];
        r_rw   <= RW;
        r_len  <= Burst_len;
        r_beat <= '0;
        Ready  <= 1'b0;
      end
      if (w_setup) begin
        Addr <= r_addr;
        if (r_rw == WR) Mem_wdata <= Wdata;
        rdEn <= (r_rw == RD);
        wrEn <= (r_rw == WR);
      end
      // Read data is still driven by the RAM here because rdEn drops on this edge.
      if (w_complete) begin
        if (r_rw == RD) Rdata <= Mem_rdata;
        Beat_done <= 1'b1;
        Last      <= w_last_beat;
        rdEn      <= 1'b0;
        wrEn      <= 1'b0;
        if (w_last_beat) begin
          Ready <= 1'b1;
        end else begin
          r_addr <= r_addr + 1'b1;
          r_beat <= r_beat + 1'b1;
        end
      end
    end
  end

endmodule
